// File: rtl/mem_seq_pkg.sv
// Shared definitions for the memory access sequencer. The state encoding is
// also used by the control unit's debug state mux, so its values are fixed.
package mem_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2,
      ERR    = 2'd3
   } mem_seq_state_e;

   // Low address bits that must be zero for a word access
   localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

   function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
      return (addr_lsb & WORD_ALIGN_MASK) == 2'b00;
   endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Request/done handshake from the control unit plus the RAM-side bus.
// The master side is the control unit together with the RAM; the slave
// side is the sequencer.
interface mem_access_sequencer_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              busy;
   logic              done;
   logic              align_err;
   logic [DATA_W-1:0] rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_wr;
   logic [DATA_W-1:0] mem_rdata;
   logic [1:0]        state_out;

   modport master (
      output req, we, addr, wdata, mem_rdata,
      input  busy, done, align_err, rdata, mem_addr, mem_wdata, mem_wr, state_out
   );

   modport slave (
      input  req, we, addr, wdata, mem_rdata,
      output busy, done, align_err, rdata, mem_addr, mem_wdata, mem_wr, state_out
   );
endinterface

// File: rtl/mem_wait_counter.sv
// Wait-state counter: cleared when an access is accepted, counts while the
// access is in progress and flags the last cycle of the hold window.
module mem_wait_counter #(
   parameter int LATENCY = 3
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tc
);
   localparam int CNT_W = $clog2(LATENCY + 1);
   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(LATENCY - 1);

   logic [CNT_W-1:0] cnt;

   // Clear has priority so a new access always starts counting from zero
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tc = (cnt == TC_VAL);
endmodule

// File: rtl/mem_access_sequencer.sv
// Memory-side sequencer between the multicycle control unit and the
// synchronous RAM. Latches an access, holds address/write data stable for
// LATENCY cycles, captures read data and pulses done. Misaligned word
// accesses are rejected without driving the RAM.
module mem_access_sequencer
   import mem_seq_pkg::*;
#(
   parameter int LATENCY = 3,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   mem_access_sequencer_if.slave bus
);

   mem_seq_state_e state;
   logic           we_q;
   logic           accept;
   logic           cnt_en;
   logic           cnt_tc;

   // An aligned request in IDLE starts a real memory access
   assign accept = (state == IDLE) && bus.req && is_word_aligned(bus.addr[1:0]);
   assign cnt_en = (state == ACCESS);

   mem_wait_counter #(
      .LATENCY (LATENCY)
   ) u_wait_counter (
      .clock  (clock),
      .reset  (reset),
      .clear  (accept),
      .enable (cnt_en),
      .tc     (cnt_tc)
   );

   // Sequencer FSM: accept/reject in IDLE, hold in ACCESS, one-cycle DONE/ERR
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         we_q          <= 1'b0;
         bus.mem_addr  <= {ADDR_W{1'b0}};
         bus.mem_wdata <= {DATA_W{1'b0}};
         bus.rdata     <= {DATA_W{1'b0}};
      end else begin
         case (state)
            IDLE: begin
               if (bus.req) begin
                  if (is_word_aligned(bus.addr[1:0])) begin
                     state         <= ACCESS;
                     we_q          <= bus.we;
                     bus.mem_addr  <= bus.addr;
                     bus.mem_wdata <= bus.wdata;
                  end else begin
                     state <= ERR;
                  end
               end
            end
            ACCESS: begin
               if (cnt_tc) begin
                  state <= DONE;
                  if (!we_q) begin
                     bus.rdata <= bus.mem_rdata;
                  end
               end
            end
            DONE:    state <= IDLE;
            ERR:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs decode straight from the state register so reset clears them at once
   assign bus.busy      = (state != IDLE);
   assign bus.done      = (state == DONE) || (state == ERR);
   assign bus.align_err = (state == ERR);
   assign bus.mem_wr    = (state == ACCESS) && we_q;
   assign bus.state_out = state;

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
Memory-side stage sitting directly downstream of the multicycle control unit, between it and the synchronous instruction/data RAM. Replaces the hard-coded wait states (Fetch_E1/E2, MemRead_E1..E3, MemWrite_E1) with an explicit request/done handshake. Latches the address and write data, holds memory signals stable for a parameterised latency, and captures read data for the IR/MDR. Flags misaligned word accesses without touching memory.

Parameters:
LATENCY, 3, memory cycles address/write must be held before read data is valid (min 1)
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
req  in  1  access request from control unit; sampled only in IDLE
we  in  1  1=write, 0=read; sampled with req
addr  in  ADDR_W  byte address; sampled with req
wdata  in  DATA_W  store data; sampled with req
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle completion pulse (DONE or ERR state)
align_err  out  1  high with done when addr[1:0]!=0
rdata  out  DATA_W  captured read data, held until next successful read
mem_addr  out  ADDR_W  registered address to RAM
mem_wdata  out  DATA_W  registered write data to RAM
mem_wr  out  1  RAM write enable (MemReadWrite polarity: 1=write)
mem_rdata  in  DATA_W  RAM read data
state_out  out  2  current state encoding, for debug/waveforms

Behaviour:
- Reset (async): state=IDLE, cnt=0, mem_addr=0, mem_wdata=0, rdata=0, we_q=0; busy=0, done=0, align_err=0, mem_wr=0 immediately (outputs decoded from state).
- States: IDLE=0, ACCESS=1, DONE=2, ERR=3.
- IDLE: req=1 and addr[1:0]==0 -> ACCESS; latch mem_addr<=addr, mem_wdata<=wdata, we_q<=we, cnt<=0. req=1 and addr[1:0]!=0 -> ERR; no latch. req=0 -> stay.
- ACCESS: mem_wr=we_q for every ACCESS cycle (idempotent repeated write). cnt increments each cycle; when cnt==LATENCY-1 -> DONE; on that edge, if we_q==0, rdata<=mem_rdata.
- DONE: done=1 for exactly one cycle -> IDLE unconditionally; req is not sampled in DONE.
- ERR: done=1, align_err=1 for one cycle -> IDLE; mem_wr=0; rdata unchanged.
- Latency: req sampled at edge E0 -> ACCESS for LATENCY cycles -> done high in cycle after edge E(LATENCY). Back-to-back: req held high gives a new accept in the IDLE cycle after DONE (throughput LATENCY+2 cycles/access).
- req/we/addr/wdata changes while busy: ignored; latched values govern the access.
- Writes never modify rdata. mem_addr/mem_wdata hold last value in IDLE.
- cnt width $clog2(LATENCY+1); LATENCY=1 gives single ACCESS cycle.
- Reset mid-ACCESS: mem_wr drops asynchronously, no done pulse, rdata keeps reset value 0.

Decomposition:
- Package mem_seq_pkg: state enum (IDLE, ACCESS, DONE, ERR; 2-bit), constant WORD_ALIGN_MASK=2'b11, state encoding reused by the control unit's debug State_out mux.
- One natural sub-module: mem_wait_counter (load/clear, enable, terminal-count flag at LATENCY-1); everything else inline.

Test Plan:
- Reset mid-write (ACCESS, we=1) -> mem_wr=0 same cycle, state_out=0, busy=0, rdata=0, no done.
- LATENCY=3: RAM preloaded 0x0000_0010=0xDEADBEEF; req,we=0,addr=0x10 at E0 -> busy cycles 1-4, done=1 only after E3, rdata=0xDEADBEEF, mem_wr never 1.
- Write addr=0x20 wdata=0x12345678 -> mem_wr=1 for exactly 3 cycles with mem_addr=0x20; subsequent read of 0x20 returns 0x12345678; rdata unchanged after the write.
- Misaligned req addr=0x22 -> next cycle done=1, align_err=1, mem_wr=0 throughout, rdata unchanged, busy for 1 cycle.
- req held high with addr changing 0x10->0x14 during ACCESS -> access uses 0x10; second access to 0x14 accepted in IDLE cycle after DONE; done pulses 5 cycles apart.
- LATENCY=1 build: read completes with done one cycle after acceptance edge (state sequence IDLE->ACCESS->DONE->IDLE).
